windowed_priority_scanner: RTL and testbench
============================================

Name: windowed_priority_scanner

Overview:
- Parametrised, sequential successor to the combinational windowed priority encoder.
- Accepts one request per handshake: a vector of NUM_LANES lanes of LANE_W bits, a lane window [left..right] and a scan direction.
- Emits every non-zero lane inside the window, one per output handshake, in priority order, then returns to idle.
- Sits between the lane-vector producer and any consumer that must service all active lanes, not just the first.

Parameters:
- NUM_LANES, 4, number of lanes in the input vector (>=2, power of two).
- LANE_W, 8, width of each lane in bits.
- IDX_W, $clog2(NUM_LANES), localparam, width of lane indices.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  scanner can accept a request.
- in_vec  input  NUM_LANES*LANE_W  lane vector; lane i = in_vec[i*LANE_W +: LANE_W].
- in_left  input  IDX_W  window start lane.
- in_right  input  IDX_W  window end lane.
- in_dir  input  1  0 = ascending from left, 1 = descending from right.
- out_valid  output  1  response beat valid.
- out_ready  input  1  consumer accepts beat.
- out_found  output  1  beat carries a real lane (0 only on an empty-window beat).
- out_index  output  IDX_W  lane index of this beat.
- out_data  output  LANE_W  lane contents of this beat.
- out_last  output  1  final beat of the current request.
- busy  output  1  a request is in progress (state != IDLE).

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state=IDLE, pending mask=0, captured vector=0, out_valid=0, out_found=0, out_index=0, out_data=0, out_last=0, busy=0, in_ready=0 while rst=1.
- Window membership: lane i is in the window iff
  - left<=right and left<=i<=right, or
  - left>right (wrap) and (i>=left or i<=right).
  - left==right selects a single lane.
- FSM with states IDLE and EMIT.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: register in_vec and in_dir.
  - Register pending = (lane!=0) AND (lane in window), per lane.
  - Register the scan origin: left if dir=0, right if dir=1.
  - Transition to EMIT.
- EMIT:
  - in_ready=0; in_valid is ignored.
  - out_valid=1.
  - dir=0: selected lane is the first set pending bit scanning origin, origin+1, ... mod NUM_LANES.
  - dir=1: scan origin, origin-1, ... mod NUM_LANES.
  - out_index = selected lane, out_data = its captured contents, out_found=1.
  - out_last=1 iff exactly one pending bit is set.
- Empty pending (no qualifying lane): emit one beat with found=0, index=0, data=0, last=1.
- On out_valid&&out_ready:
  - Clear the selected pending bit.
  - If out_last was 1, go to IDLE.
- Latency: first out_valid is the cycle after the acceptance cycle. Each subsequent beat follows one cycle after the previous handshake.
- in_ready is 1 in the cycle after the last handshake; there is no same-cycle re-accept.
- Backpressure: while out_valid&&!out_ready, all out_* outputs hold stable.
- All out_* outputs are driven from registered state (pending mask, captured vector, origin, dir) via combinational selection; there are no combinational paths from in_* to out_*.
- Reset mid-EMIT: the next cycle is IDLE, out_valid=0 and pending=0; no stale beats follow.
- Width rules: index arithmetic is modulo NUM_LANES in IDX_W bits. Lane-zero test is the OR-reduction of the lane.

Decomposition:
- Package functions gains the following; NUM_LANES and LANE_W are supplied as package-level defaults matching the module parameters.
  - typedef scan_req_t {vec, left, right, dir}.
  - typedef scan_rsp_t {found, index, data, last}.
  - function window_mask(left, right) returning a NUM_LANES-bit mask.
  - function rotated_first_set(mask, origin, dir) returning an index plus a hit flag.
- One sub-module: priority_pick. Combinational; takes pending mask, origin and dir; produces selected index, any-set flag and single-bit flag. It is the generalised successor of priority_encoder.

Test Plan (NUM_LANES=4, LANE_W=8):
- Lanes {0:00,1:01,2:00,3:03}, left=1, right=3, dir=0, out_ready=1 -> beats (found1, idx1, data01, last0) then (found1, idx3, data03, last1); in_ready=1 the following cycle.
- Same vector and window, dir=1 -> beats idx3/data03/last0, then idx1/data01/last1.
- Lanes {0:05,1:00,2:00,3:07}, left=1, right=2 -> single beat found0, idx0, data00, last1.
- Wrap: lanes {0:AA,1:BB,2:00,3:CC}, left=3, right=0, dir=0 -> idx3/CC, then idx0/AA/last1; lane1 never emitted.
- Backpressure: case 1 with out_ready=0 for 3 cycles on the first beat, plus a second in_valid pulse -> outputs stable at idx1/01 and in_ready=0. The second request is not taken; the sequence completes as in case 1.
- Reset mid-EMIT: assert rst for one cycle after the first beat of case 1 -> next cycle out_valid=0, busy=0, in_ready=1; idx3 is never emitted.

Source files
------------

// File: rtl/windowed_priority_scanner_pkg.sv
// Shared types and helpers for the windowed priority scanner.
// NUM_LANES/LANE_W here are the defaults the modules pick up.
package windowed_priority_scanner_pkg;

   localparam int NUM_LANES = 4;
   localparam int LANE_W    = 8;
   localparam int IDX_W     = $clog2(NUM_LANES);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } scan_state_t;

   typedef struct packed {
      logic [NUM_LANES*LANE_W-1:0] vec;
      logic [IDX_W-1:0]            left;
      logic [IDX_W-1:0]            right;
      logic                        dir;
   } scan_req_t;

   typedef struct packed {
      logic              found;
      logic [IDX_W-1:0]  index;
      logic [LANE_W-1:0] data;
      logic              last;
   } scan_rsp_t;

   typedef struct packed {
      logic             hit;
      logic [IDX_W-1:0] index;
   } pick_t;

   // left > right means the window wraps through lane NUM_LANES-1 back to lane 0
   function automatic logic [NUM_LANES-1:0] window_mask(input logic [IDX_W-1:0] left,
                                                        input logic [IDX_W-1:0] right);
      logic [NUM_LANES-1:0] m;
      m = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (left <= right)
            m[i] = (IDX_W'(i) >= left) && (IDX_W'(i) <= right);
         else
            m[i] = (IDX_W'(i) >= left) || (IDX_W'(i) <= right);
      end
      return m;
   endfunction

   function automatic pick_t rotated_first_set(input logic [NUM_LANES-1:0] mask,
                                               input logic [IDX_W-1:0]     origin,
                                               input logic                 dir);
      pick_t            p;
      logic [IDX_W-1:0] lane;
      p = '0;
      for (int k = NUM_LANES - 1; k >= 0; k--) begin
         lane = dir ? origin - IDX_W'(k) : origin + IDX_W'(k);
         if (mask[lane]) begin
            p.hit   = 1'b1;
            p.index = lane;
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/windowed_priority_scanner_priority_pick.sv
// Rotating priority pick: first set mask bit walking from origin in the
// requested direction, modulo NUM_LANES, plus any-set and single-set flags.
module windowed_priority_scanner_priority_pick #(
   parameter  int NUM_LANES = windowed_priority_scanner_pkg::NUM_LANES,
   localparam int IDX_W     = $clog2(NUM_LANES)
) (
   input  logic [NUM_LANES-1:0] mask,
   input  logic [IDX_W-1:0]     origin,
   input  logic                 dir,
   output logic [IDX_W-1:0]     index,
   output logic                 any_set,
   output logic                 single
);

   logic [IDX_W-1:0] lane;

   // walk farthest-first so the closest set lane to origin is the one left standing
   always_comb begin
      index = '0;
      lane  = '0;
      for (int k = NUM_LANES - 1; k >= 0; k--) begin
         lane = dir ? origin - IDX_W'(k) : origin + IDX_W'(k);
         if (mask[lane])
            index = lane;
      end
   end

   assign any_set = |mask;
   assign single  = any_set && ((mask & (mask - NUM_LANES'(1))) == '0);

endmodule

// File: rtl/windowed_priority_scanner.sv
// Sequential windowed scanner: captures one lane vector and emits every
// non-zero lane inside the window, one per handshake, in priority order.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request; outputs quiet
// EMIT  | presenting beats from the pending mask until the last is taken
module windowed_priority_scanner #(
   parameter  int NUM_LANES = windowed_priority_scanner_pkg::NUM_LANES,
   parameter  int LANE_W    = windowed_priority_scanner_pkg::LANE_W,
   localparam int IDX_W     = $clog2(NUM_LANES)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [NUM_LANES*LANE_W-1:0] in_vec,
   input  logic [IDX_W-1:0]            in_left,
   input  logic [IDX_W-1:0]            in_right,
   input  logic                        in_dir,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        out_found,
   output logic [IDX_W-1:0]            out_index,
   output logic [LANE_W-1:0]           out_data,
   output logic                        out_last,
   output logic                        busy
);
   import windowed_priority_scanner_pkg::*;

   scan_state_t          state_q, state_d;
   logic [NUM_LANES-1:0] pending_q, pending_d;
   logic [LANE_W-1:0]    lane_q [NUM_LANES];
   logic [IDX_W-1:0]     origin_q;
   logic                 dir_q;

   logic [IDX_W-1:0]     sel_index;
   logic                 sel_any;
   logic                 sel_single;
   logic                 accept;
   logic                 emit_hs;

   assign accept  = in_valid && in_ready;
   assign emit_hs = out_valid && out_ready;

   // qualifying lanes of the incoming request: inside the window and non-zero
   always_comb begin
      logic in_win;
      pending_d = '0;
      in_win    = 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (in_left <= in_right)
            in_win = (IDX_W'(i) >= in_left) && (IDX_W'(i) <= in_right);
         else
            in_win = (IDX_W'(i) >= in_left) || (IDX_W'(i) <= in_right);
         pending_d[i] = in_win && (|in_vec[i*LANE_W +: LANE_W]);
      end
   end

   windowed_priority_scanner_priority_pick #(
      .NUM_LANES (NUM_LANES)
   ) u_pick (
      .mask    (pending_q),
      .origin  (origin_q),
      .dir     (dir_q),
      .index   (sel_index),
      .any_set (sel_any),
      .single  (sel_single)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept)                state_d = ST_EMIT;
         ST_EMIT: if (emit_hs && out_last)   state_d = ST_IDLE;
         default:                            state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
         origin_q  <= '0;
         dir_q     <= 1'b0;
         for (int i = 0; i < NUM_LANES; i++)
            lane_q[i] <= '0;
      end else if (accept) begin
         pending_q <= pending_d;
         origin_q  <= in_dir ? in_right : in_left;
         dir_q     <= in_dir;
         for (int i = 0; i < NUM_LANES; i++)
            lane_q[i] <= in_vec[i*LANE_W +: LANE_W];
      end else if (emit_hs) begin
         pending_q[sel_index] <= 1'b0;
      end
   end

   // outputs are held quiet while rst is asserted, whatever the state register holds
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_found = 1'b0;
      out_index = '0;
      out_data  = '0;
      out_last  = 1'b0;
      busy      = 1'b0;
      if (!rst) begin
         case (state_q)
            ST_IDLE: in_ready = 1'b1;
            ST_EMIT: begin
               busy      = 1'b1;
               out_valid = 1'b1;
               if (sel_any) begin
                  out_found = 1'b1;
                  out_index = sel_index;
                  out_data  = lane_q[sel_index];
                  out_last  = sel_single;
               end else begin
                  out_last  = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_windowed_priority_scanner.sv
// Randomised bench for windowed_priority_scanner against a lane-list reference
// model; directed cases cover wrap, empty window, backpressure and mid-scan reset.
module tb_windowed_priority_scanner;

   localparam int N  = 4;
   localparam int LW = 8;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [N*LW-1:0] in_vec;
   logic [IW-1:0] in_left;
   logic [IW-1:0] in_right;
   logic          in_dir;
   logic          out_valid;
   logic          out_ready;
   logic          out_found;
   logic [IW-1:0] out_index;
   logic [LW-1:0] out_data;
   logic          out_last;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      bit found;
      int idx;
      int data;
      bit last;
   } beat_t;

   always #5 clk = ~clk;

   windowed_priority_scanner #(.NUM_LANES(N), .LANE_W(LW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .in_left   (in_left),
      .in_right  (in_right),
      .in_dir    (in_dir),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_found (out_found),
      .out_index (out_index),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // reference: list the qualifying lanes in visiting order from the origin
   task automatic build_expect(input logic [31:0] vec, input int left, input int right,
                               input bit dir, output beat_t q[$]);
      int    origin;
      int    i;
      int    lane;
      bit    in_win;
      beat_t b;
      q = {};
      origin = dir ? right : left;
      for (int k = 0; k < N; k++) begin
         i      = dir ? (origin - k + N) % N : (origin + k) % N;
         lane   = int'((vec >> (i * LW)) & 32'hFF);
         in_win = (left <= right) ? (i >= left && i <= right) : (i >= left || i <= right);
         if (in_win && lane != 0) begin
            b.found = 1; b.idx = i; b.data = lane; b.last = 0;
            q.push_back(b);
         end
      end
      if (q.size() == 0) begin
         b.found = 0; b.idx = 0; b.data = 0; b.last = 1;
         q.push_back(b);
      end else begin
         q[q.size()-1].last = 1;
      end
   endtask

   task automatic run_req(input logic [31:0] vec, input int left, input int right,
                          input bit dir, input int bp_pct, input int hold_first, input bit stray);
      beat_t exp_q[$];
      int    cyc;
      bit    hs;
      logic [31:0] snap;
      build_expect(vec, left, right, dir, exp_q);
      chk("idle_in_ready", 32'(in_ready), 32'd1);
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      in_vec   = vec;
      in_left  = IW'(left);
      in_right = IW'(right);
      in_dir   = dir;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 100) begin
         chk("emit_valid", 32'(out_valid), 32'd1);
         chk("emit_in_ready", 32'(in_ready), 32'd0);
         chk("emit_busy", 32'(busy), 32'd1);
         if (stray) begin
            in_valid = 1'($urandom_range(0, 1));
            in_vec   = $urandom;
            in_left  = IW'($urandom_range(0, N-1));
            in_right = IW'($urandom_range(0, N-1));
         end
         if (cyc < hold_first)
            out_ready = 1'b0;
         else
            out_ready = ($urandom_range(0, 99) >= bp_pct);
         hs   = out_ready;
         snap = {20'd0, out_valid, out_found, out_index, out_data};
         if (hs) begin
            chk("beat_found", 32'(out_found), 32'(exp_q[0].found));
            chk("beat_index", 32'(out_index), 32'(exp_q[0].idx));
            chk("beat_data", 32'(out_data), 32'(exp_q[0].data));
            chk("beat_last", 32'(out_last), 32'(exp_q[0].last));
            void'(exp_q.pop_front());
         end else begin
            chk("stall_last", 32'(out_last), 32'(exp_q.size() == 1));
         end
         tick();
         if (!hs)
            chk("stall_hold", {20'd0, out_valid, out_found, out_index, out_data}, snap);
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("beats_drained", 32'(exp_q.size()), 32'd0);
      chk("after_out_valid", 32'(out_valid), 32'd0);
      chk("after_in_ready", 32'(in_ready), 32'd1);
      chk("after_busy", 32'(busy), 32'd0);
   endtask

   task automatic reset_mid_emit();
      chk("rme_in_ready", 32'(in_ready), 32'd1);
      in_vec = 32'h0300_0100; in_left = 2'd1; in_right = 2'd3; in_dir = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("rme_first_index", 32'(out_index), 32'd1);
      chk("rme_first_data", 32'(out_data), 32'h01);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("rme_second_pending", 32'(out_index), 32'd3);
      rst = 1'b1;
      #1;
      chk("rme_in_ready_in_rst", 32'(in_ready), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      chk("rme_out_valid", 32'(out_valid), 32'd0);
      chk("rme_busy", 32'(busy), 32'd0);
      chk("rme_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("rme_no_stale", 32'(out_valid), 32'd0);
      end
      out_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] v;
      rst = 1'b1; in_valid = 1'b0; in_vec = '0; in_left = '0; in_right = '0;
      in_dir = 1'b0; out_ready = 1'b0;
      tick();
      tick();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_out_fields", {22'd0, out_found, out_index, out_data, out_last}, 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      run_req(32'h0300_0100, 1, 3, 1'b0, 0, 0, 1'b0);
      run_req(32'h0300_0100, 1, 3, 1'b1, 0, 0, 1'b0);
      run_req(32'h0700_0005, 1, 2, 1'b0, 0, 0, 1'b0);
      run_req(32'hCC00_BBAA, 3, 0, 1'b0, 0, 0, 1'b0);
      run_req(32'h0300_0100, 1, 1, 1'b0, 0, 0, 1'b0);
      run_req(32'h0300_0100, 1, 3, 1'b0, 0, 3, 1'b1);
      reset_mid_emit();

      for (int r = 0; r < 200; r++) begin
         v = '0;
         for (int l = 0; l < N; l++)
            if ($urandom_range(0, 2) != 0)
               v[l*LW +: LW] = 8'($urandom_range(1, 255));
         run_req(v, $urandom_range(0, N-1), $urandom_range(0, N-1),
                 1'($urandom_range(0, 1)), 35, 0, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
